uart_bus_bridge: RTL and testbench



---
 rtl/uart_bus_bridge.sv | 397 +++++++++++++++++++++++++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_bridge.sv
// -----------------------------------------------------------------------------
// uart_bus_bridge
//   ASCII command shell between a UART receiver/transmitter pair and a simple
//   request/ack system bus. Lines typed on the UART are buffered, then parsed as
//       rd <addr>           -> one bus read,  reply "<addr>:<data>\r\n"
//       wr <addr> <data>    -> one bus write, reply "OK\r\n"
//       dm <addr> <nn>      -> nn consecutive reads, one reply line per word
//   Malformed lines reply "ER\r\n"; a bus cycle without ack within TIMEOUT
//   clocks replies "TO\r\n"; an empty line replies "\r\n".
//
// Optional feature macro: ECHO_EN
//   When defined, every byte accepted in S_RX is echoed to the transmitter
//   (only if the transmitter is idle). Undefined: the transmitter is used for
//   responses only.
//
// Ports
//   CLK, r_reset            clock, synchronous active-high reset
//   i_rx_dv, i_rx_byte      received byte strobe / byte from UART_RX
//   o_tx_dv, o_tx_byte      transmit strobe / byte to UART_TX
//   i_tx_active, i_tx_done  UART_TX busy / byte-complete strobe
//   o_bus_cs, o_bus_we      bus request (held until ack/timeout), write enable
//   o_bus_addr, o_bus_wdata bus address, write data
//   i_bus_rdata, i_bus_ack  read data (sampled with ack), cycle complete
//   o_busy                  high whenever the shell is not collecting a line
//   o_overrun               one-cycle pulse per dropped received byte
// -----------------------------------------------------------------------------
module uart_bus_bridge #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int CMD_MAX = 24,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              r_reset,
    input  logic              i_rx_dv,
    input  logic [7:0]        i_rx_byte,
    output logic              o_tx_dv,
    output logic [7:0]        o_tx_byte,
    input  logic              i_tx_active,
    input  logic              i_tx_done,
    output logic              o_bus_cs,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_wdata,
    input  logic [DATA_W-1:0] i_bus_rdata,
    input  logic              i_bus_ack,
    output logic              o_busy,
    output logic              o_overrun
);

    localparam int NA      = ADDR_W / 4;
    localparam int ND      = DATA_W / 4;
    localparam int LEN_RD  = 3 + NA;
    localparam int LEN_WR  = 4 + NA + ND;
    localparam int LEN_DM  = 6 + NA;
    localparam int RESP_N  = NA + ND + 3;
    localparam int IDX_W   = $clog2(CMD_MAX + 1);
    localparam int RESP_W  = $clog2(RESP_N + 1);
    localparam int TMR_W   = $clog2(TIMEOUT + 1);

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_D     = 8'h64;
    localparam logic [7:0] CH_M     = 8'h6D;
    localparam logic [7:0] CH_R     = 8'h72;
    localparam logic [7:0] CH_W     = 8'h77;
    localparam logic [7:0] CH_UE    = 8'h45;
    localparam logic [7:0] CH_UK    = 8'h4B;
    localparam logic [7:0] CH_UO    = 8'h4F;
    localparam logic [7:0] CH_UR    = 8'h52;
    localparam logic [7:0] CH_UT    = 8'h54;

    typedef enum logic [2:0] {
        S_RX, S_PARSE, S_BUS, S_RESP, S_TX_WAIT, S_TX_BYTE, S_TX_DONE
    } state_t;

    typedef enum logic [2:0] {
        K_RD, K_WR, K_ER, K_TO, K_NL
    } kind_t;

    // ---------------------------------------------------------------- helpers
    function automatic logic is_hex(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) ||
               ((c >= 8'h41) && (c <= 8'h46)) ||
               ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    function automatic logic [3:0] hex_nib(input logic [7:0] c);
        logic [7:0] t;
        if ((c >= 8'h30) && (c <= 8'h39)) begin
            t = c - 8'h30;
        end else if ((c >= 8'h41) && (c <= 8'h46)) begin
            t = c - 8'h37;
        end else if ((c >= 8'h61) && (c <= 8'h66)) begin
            t = c - 8'h57;
        end else begin
            t = 8'h00;
        end
        return t[3:0];
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end else begin
            return 8'h37 + {4'h0, n};
        end
    endfunction

    // -------------------------------------------------------------- registers
    state_t              r_state;
    kind_t               r_kind;
    logic [7:0]          r_line [CMD_MAX];
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    r_len;
    logic                r_ovf;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_bus_we;
    logic                r_bus_cs;
    logic [TMR_W-1:0]    r_timer;
    logic [7:0]          r_count;
    logic [7:0]          r_resp [RESP_N];
    logic [RESP_W-1:0]   r_resp_len;
    logic [RESP_W-1:0]   r_tx_idx;
    logic                r_tx_dv;
    logic [7:0]          r_tx_byte;
    logic                r_busy;
    logic                r_overrun;
    logic                w_echo_block;

`ifdef ECHO_EN
    logic                r_echo_pend;
    // Response bytes wait until an in-flight echo byte has completed.
    assign w_echo_block = r_echo_pend;
`else
    assign w_echo_block = 1'b0;
`endif

    // ------------------------------------------------------------ line parse
    logic                w_addr_ok;
    logic                w_data_ok;
    logic                w_cnt_ok;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;
    logic [7:0]          w_cnt;
    logic                w_is_rd;
    logic                w_is_wr;
    logic                w_is_dm;
    logic                w_printable;

    assign w_printable = (i_rx_byte >= 8'h20) && (i_rx_byte <= 8'h7E);

    // Decode the buffered line into one of the three command shapes.
    always_comb begin
        w_addr_ok = 1'b1;
        w_data_ok = 1'b1;
        w_addr    = '0;
        w_data    = '0;
        for (int i = 0; i < NA; i++) begin
            w_addr_ok = w_addr_ok & is_hex(r_line[3 + i]);
            w_addr    = (w_addr << 4) | ADDR_W'(hex_nib(r_line[3 + i]));
        end
        for (int i = 0; i < ND; i++) begin
            w_data_ok = w_data_ok & is_hex(r_line[4 + NA + i]);
            w_data    = (w_data << 4) | DATA_W'(hex_nib(r_line[4 + NA + i]));
        end
        w_cnt    = {hex_nib(r_line[4 + NA]), hex_nib(r_line[5 + NA])};
        w_cnt_ok = is_hex(r_line[4 + NA]) & is_hex(r_line[5 + NA]) & (w_cnt != 8'd0);

        w_is_rd = (r_len == IDX_W'(LEN_RD)) && (r_line[0] == CH_R) &&
                  (r_line[1] == CH_D) && (r_line[2] == CH_SP) && w_addr_ok;
        w_is_wr = (r_len == IDX_W'(LEN_WR)) && (r_line[0] == CH_W) &&
                  (r_line[1] == CH_R) && (r_line[2] == CH_SP) && w_addr_ok &&
                  (r_line[3 + NA] == CH_SP) && w_data_ok;
        w_is_dm = (r_len == IDX_W'(LEN_DM)) && (r_line[0] == CH_D) &&
                  (r_line[1] == CH_M) && (r_line[2] == CH_SP) && w_addr_ok &&
                  (r_line[3 + NA] == CH_SP) && w_cnt_ok;
    end

    // ------------------------------------------------------------ main FSM
    // Line collection, parse, bus handshake, response build and transmit.
    always_ff @(posedge CLK) begin
        if (r_reset) begin
            r_state    <= S_RX;
            r_kind     <= K_NL;
            r_idx      <= '0;
            r_len      <= '0;
            r_ovf      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_bus_we   <= 1'b0;
            r_bus_cs   <= 1'b0;
            r_timer    <= '0;
            r_count    <= 8'd0;
            r_resp_len <= '0;
            r_tx_idx   <= '0;
            r_tx_dv    <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
`ifdef ECHO_EN
            r_echo_pend <= 1'b0;
`endif
        end else begin
            r_tx_dv   <= 1'b0;
            r_overrun <= i_rx_dv && (r_state != S_RX);
`ifdef ECHO_EN
            if (i_tx_done) begin
                r_echo_pend <= 1'b0;
            end
`endif
            case (r_state)
                S_RX: begin
                    if (i_rx_dv) begin
                        if (i_rx_byte == CH_CR) begin
                            r_len   <= r_idx;
                            r_state <= S_PARSE;
                            r_busy  <= 1'b1;
                        end else if (i_rx_byte == CH_BS) begin
                            if (r_idx != '0) begin
                                r_idx <= r_idx - IDX_W'(1);
                            end
                        end else if (w_printable) begin
                            if (r_idx == IDX_W'(CMD_MAX)) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_line[r_idx] <= i_rx_byte;
                                r_idx         <= r_idx + IDX_W'(1);
                            end
                        end
`ifdef ECHO_EN
                        // Overflowed and non-printable bytes are not echoed.
                        if (!i_tx_active &&
                            ((i_rx_byte == CH_CR) || (i_rx_byte == CH_BS) ||
                             (w_printable && (r_idx != IDX_W'(CMD_MAX))))) begin
                            r_tx_dv     <= 1'b1;
                            r_tx_byte   <= i_rx_byte;
                            r_echo_pend <= 1'b1;
                        end
`endif
                    end
                end

                S_PARSE: begin
                    r_idx   <= '0;
                    r_ovf   <= 1'b0;
                    r_count <= 8'd1;
                    if (r_ovf) begin
                        r_kind  <= K_ER;
                        r_state <= S_RESP;
                    end else if (r_len == '0) begin
                        r_kind  <= K_NL;
                        r_state <= S_RESP;
                    end else if (w_is_rd) begin
                        r_kind   <= K_RD;
                        r_addr   <= w_addr;
                        r_bus_we <= 1'b0;
                        r_state  <= S_BUS;
                    end else if (w_is_wr) begin
                        r_kind   <= K_WR;
                        r_addr   <= w_addr;
                        r_wdata  <= w_data;
                        r_bus_we <= 1'b1;
                        r_state  <= S_BUS;
                    end else if (w_is_dm) begin
                        r_kind   <= K_RD;
                        r_addr   <= w_addr;
                        r_count  <= w_cnt;
                        r_bus_we <= 1'b0;
                        r_state  <= S_BUS;
                    end else begin
                        r_kind  <= K_ER;
                        r_state <= S_RESP;
                    end
                end

                S_BUS: begin
                    // First cycle raises cs; ack may already be present in
                    // the cycle cs is first seen high.
                    if (!r_bus_cs) begin
                        r_bus_cs <= 1'b1;
                        r_timer  <= '0;
                    end else if (i_bus_ack) begin
                        r_bus_cs <= 1'b0;
                        r_rdata  <= i_bus_rdata;
                        r_state  <= S_RESP;
                    end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                        r_bus_cs <= 1'b0;
                        r_kind   <= K_TO;
                        r_state  <= S_RESP;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end

                S_RESP: begin
                    r_tx_idx <= '0;
                    r_state  <= S_TX_WAIT;
                    case (r_kind)
                        K_RD: begin
                            for (int i = 0; i < NA; i++) begin
                                r_resp[i] <= hex_char(r_addr[ADDR_W - 1 - 4 * i -: 4]);
                            end
                            r_resp[NA] <= CH_COLON;
                            for (int i = 0; i < ND; i++) begin
                                r_resp[NA + 1 + i] <= hex_char(r_rdata[DATA_W - 1 - 4 * i -: 4]);
                            end
                            r_resp[NA + ND + 1] <= CH_CR;
                            r_resp[NA + ND + 2] <= CH_LF;
                            r_resp_len <= RESP_W'(RESP_N);
                        end
                        K_WR: begin
                            r_resp[0]  <= CH_UO;
                            r_resp[1]  <= CH_UK;
                            r_resp[2]  <= CH_CR;
                            r_resp[3]  <= CH_LF;
                            r_resp_len <= RESP_W'(4);
                        end
                        K_TO: begin
                            r_resp[0]  <= CH_UT;
                            r_resp[1]  <= CH_UO;
                            r_resp[2]  <= CH_CR;
                            r_resp[3]  <= CH_LF;
                            r_resp_len <= RESP_W'(4);
                        end
                        K_NL: begin
                            r_resp[0]  <= CH_CR;
                            r_resp[1]  <= CH_LF;
                            r_resp_len <= RESP_W'(2);
                        end
                        default: begin
                            r_resp[0]  <= CH_UE;
                            r_resp[1]  <= CH_UR;
                            r_resp[2]  <= CH_CR;
                            r_resp[3]  <= CH_LF;
                            r_resp_len <= RESP_W'(4);
                        end
                    endcase
                end

                S_TX_WAIT: begin
                    if (!i_tx_active && !w_echo_block) begin
                        r_tx_dv   <= 1'b1;
                        r_tx_byte <= r_resp[r_tx_idx];
                        r_state   <= S_TX_BYTE;
                    end
                end

                S_TX_BYTE: begin
                    if (i_tx_done) begin
                        if (r_tx_idx == (r_resp_len - RESP_W'(1))) begin
                            r_state <= S_TX_DONE;
                        end else begin
                            r_tx_idx <= r_tx_idx + RESP_W'(1);
                            r_state  <= S_TX_WAIT;
                        end
                    end
                end

                S_TX_DONE: begin
                    // A timeout changes the kind to K_TO, which ends a dump.
                    if ((r_kind == K_RD) && (r_count > 8'd1)) begin
                        r_count <= r_count - 8'd1;
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_state <= S_BUS;
                    end else begin
                        r_state <= S_RX;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state  <= S_RX;
                    r_bus_cs <= 1'b0;
                    r_busy   <= 1'b0;
                    r_idx    <= '0;
                end
            endcase
        end
    end

    assign o_tx_dv     = r_tx_dv;
    assign o_tx_byte   = r_tx_byte;
    assign o_bus_cs    = r_bus_cs;
    assign o_bus_we    = r_bus_we;
    assign o_bus_addr  = r_addr;
    assign o_bus_wdata = r_wdata;
    assign o_busy      = r_busy;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_bus_bridge
//   Directed bench for uart_bus_bridge (ADDR_W = DATA_W = 16, CMD_MAX = 24,
//   TIMEOUT = 255). Behavioural UART_TX and bus slave models surround the DUT;
//   each step sends a command line and checks the bus log and transmitted text
//   against hand-written expectations.
// -----------------------------------------------------------------------------
module tb_uart_bus_bridge;

    logic        CLK = 1'b0;
    logic        r_reset;
    logic        i_rx_dv;
    logic [7:0]  i_rx_byte;
    logic        o_tx_dv;
    logic [7:0]  o_tx_byte;
    logic        i_tx_active;
    logic        i_tx_done;
    logic        o_bus_cs;
    logic        o_bus_we;
    logic [15:0] o_bus_addr;
    logic [15:0] o_bus_wdata;
    logic [15:0] i_bus_rdata;
    logic        i_bus_ack;
    logic        o_busy;
    logic        o_overrun;

    int n_cmp = 0;
    int n_bad = 0;

    // bus slave controls (driven by the stimulus)
    int          ack_delay = 0;
    bit          ack_en    = 1'b1;
    bit          rdata_inc = 1'b0;
    logic [15:0] rdata_fix = 16'hBEEF;

    // model state (written only by the model processes)
    int          cs_cycles = 0;
    int          last_run  = 0;
    int          ovr_cnt   = 0;
    int          tx_cnt    = 0;
    logic [32:0] bus_q[$];
    logic [7:0]  tx_q[$];

    int tx_mark  = 0;
    int bus_mark = 0;
    int ovr_mark = 0;

    always #5 CLK = ~CLK;

    uart_bus_bridge #(
        .ADDR_W (16),
        .DATA_W (16),
        .CMD_MAX(24),
        .TIMEOUT(255)
    ) dut (
        .CLK        (CLK),
        .r_reset    (r_reset),
        .i_rx_dv    (i_rx_dv),
        .i_rx_byte  (i_rx_byte),
        .o_tx_dv    (o_tx_dv),
        .o_tx_byte  (o_tx_byte),
        .i_tx_active(i_tx_active),
        .i_tx_done  (i_tx_done),
        .o_bus_cs   (o_bus_cs),
        .o_bus_we   (o_bus_we),
        .o_bus_addr (o_bus_addr),
        .o_bus_wdata(o_bus_wdata),
        .i_bus_rdata(i_bus_rdata),
        .i_bus_ack  (i_bus_ack),
        .o_busy     (o_busy),
        .o_overrun  (o_overrun)
    );

    // Bus slave: ack after ack_delay cycles of cs (0 = same cycle as cs rise).
    assign i_bus_ack   = o_bus_cs && ack_en && (cs_cycles == ack_delay);
    assign i_bus_rdata = rdata_inc ? (o_bus_addr + 16'd1) : rdata_fix;

    // Bus log, cs run length and overrun pulse counter.
    always @(posedge CLK) begin
        if (o_bus_cs && i_bus_ack) begin
            bus_q.push_back({o_bus_we, o_bus_addr, o_bus_wdata});
        end
        if (o_bus_cs) begin
            cs_cycles <= cs_cycles + 1;
        end else begin
            if (cs_cycles != 0) last_run <= cs_cycles;
            cs_cycles <= 0;
        end
        if (o_overrun) ovr_cnt <= ovr_cnt + 1;
    end

    // UART_TX model: busy 4 cycles per byte, then a done strobe.
    always @(posedge CLK) begin
        if (r_reset) begin
            tx_cnt      <= 0;
            i_tx_active <= 1'b0;
            i_tx_done   <= 1'b0;
        end else begin
            i_tx_done <= 1'b0;
            if (o_tx_dv) begin
                tx_q.push_back(o_tx_byte);
                i_tx_active <= 1'b1;
                tx_cnt      <= 4;
            end else if (tx_cnt != 0) begin
                tx_cnt <= tx_cnt - 1;
                if (tx_cnt == 1) begin
                    i_tx_done   <= 1'b1;
                    i_tx_active <= 1'b0;
                end
            end
        end
    end

    function automatic string vis(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0D)      r = {r, "<CR>"};
            else if (s[i] == 8'h0A) r = {r, "<LF>"};
            else                    r = $sformatf("%s%c", r, s[i]);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_tx(input string tag, input string exp);
        string got = "";
        for (int i = tx_mark; i < tx_q.size(); i++) got = $sformatf("%s%c", got, tx_q[i]);
        tx_mark = tx_q.size();
        n_cmp++;
        assert (got == exp) else begin
            n_bad++;
            $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, vis(got), vis(exp));
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        i_rx_dv   = 1'b1;
        i_rx_byte = b;
        @(negedge CLK);
        i_rx_dv   = 1'b0;
        @(negedge CLK);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge CLK);
            if (!o_busy && !i_tx_active) done = 1'b1;
        end
        repeat (2) @(negedge CLK);
        n_cmp++;
        assert (done === 1'b1) else begin
            n_bad++;
            $error("FAIL %s_idle: observed busy after 3000 cycles, expected idle", tag);
        end
    endtask

    task automatic mark();
        tx_mark  = tx_q.size();
        bus_mark = bus_q.size();
        ovr_mark = ovr_cnt;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        r_reset   = 1'b1;
        i_rx_dv   = 1'b0;
        i_rx_byte = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy",    o_busy,    0);
        chk("rst_tx_dv",   o_tx_dv,   0);
        chk("rst_cs",      o_bus_cs,  0);
        chk("rst_overrun", o_overrun, 0);
        @(negedge CLK);
        r_reset = 1'b0;
        repeat (2) @(negedge CLK);

        // write, ack after 3 cycles
        mark(); ack_delay = 3;
        send_str("wr 0012 BEEF\015");
        wait_idle("wr");
        chk("wr_ncyc", bus_q.size() - bus_mark, 1);
        chk("wr_cycle", bus_q[bus_mark], 33'h1_0012_BEEF);
        chk_tx("wr_tx", "OK\015\012");

        // read, ack after 1 cycle
        mark(); ack_delay = 1;
        send_str("rd 0012\015");
        wait_idle("rd");
        chk("rd_ncyc", bus_q.size() - bus_mark, 1);
        chk("rd_we_addr", bus_q[bus_mark][32:16], 17'h0_0012);
        chk_tx("rd_tx", "0012:BEEF\015\012");

        // lower-case hex input, upper-case output
        mark();
        send_str("rd 00ab\015");
        wait_idle("rdlc");
        chk("rdlc_addr", bus_q[bus_mark][32:16], 17'h0_00AB);
        chk_tx("rdlc_tx", "00AB:BEEF\015\012");

        // dump across the address wrap, single-cycle ack
        mark(); ack_delay = 0; rdata_inc = 1'b1;
        send_str("dm FFFE 03\015");
        wait_idle("dm");
        chk("dm_ncyc", bus_q.size() - bus_mark, 3);
        chk("dm_a0", bus_q[bus_mark][32:16],     17'h0_FFFE);
        chk("dm_a1", bus_q[bus_mark + 1][32:16], 17'h0_FFFF);
        chk("dm_a2", bus_q[bus_mark + 2][32:16], 17'h0_0000);
        chk_tx("dm_tx", "FFFE:FFFF\015\012FFFF:0000\015\0120000:0001\015\012");
        rdata_inc = 1'b0;

        // timeout
        mark(); ack_en = 1'b0;
        send_str("rd 0040\015");
        wait_idle("to");
        chk("to_run", last_run, 255);
        chk("to_ncyc", bus_q.size() - bus_mark, 0);
        chk_tx("to_tx", "TO\015\012");
        ack_en = 1'b1; ack_delay = 1;

        // malformed lines
        mark();
        send_str("rx 1234\015");
        wait_idle("er1");
        chk_tx("er1_tx", "ER\015\012");
        send_str("wr 12G4 0000\015");
        wait_idle("er2");
        chk_tx("er2_tx", "ER\015\012");
        send_str("aaaaaaaaaaaaaaaaaaaaaaaaaaaaaa\015");
        wait_idle("er3");
        chk_tx("er3_tx", "ER\015\012");
        send_str("dm 0010 00\015");
        wait_idle("er4");
        chk_tx("er4_tx", "ER\015\012");
        chk("er_ncyc", bus_q.size() - bus_mark, 0);

        // empty line
        mark();
        send_str("\015");
        wait_idle("nl");
        chk_tx("nl_tx", "\015\012");

        // backspace editing
        mark();
        send_str({"rd 00", "\010\010", "0012\015"});
        wait_idle("bs");
        chk("bs_ncyc", bus_q.size() - bus_mark, 1);
        chk("bs_addr", bus_q[bus_mark][32:16], 17'h0_0012);
        chk_tx("bs_tx", "0012:BEEF\015\012");

        // bytes arriving while the response is being sent
        mark();
        send_str("rd 0012\015");
        repeat (12) @(negedge CLK);
        send_byte(8'h41);
        send_byte(8'h42);
        wait_idle("ovr");
        chk("ovr_pulses", ovr_cnt - ovr_mark, 2);
        chk_tx("ovr_tx", "0012:BEEF\015\012");

        // reset in the middle of a dump
        mark();
        send_str("dm 0000 05\015");
        hit = 1'b0;
        for (int k = 0; k < 3000 && !hit; k++) begin
            @(negedge CLK);
            if (tx_q.size() >= tx_mark + 13) hit = 1'b1;
        end
        chk("mid_reached", hit, 1);
        r_reset = 1'b1;
        @(posedge CLK);
        #1;
        chk("mid_cs",    o_bus_cs, 0);
        chk("mid_tx_dv", o_tx_dv,  0);
        chk("mid_busy",  o_busy,   0);
        @(negedge CLK);
        r_reset = 1'b0;
        repeat (2) @(negedge CLK);

        // recovery after reset
        mark();
        send_str("rd 0012\015");
        wait_idle("post");
        chk("post_addr", bus_q[bus_mark][32:16], 17'h0_0012);
        chk_tx("post_tx", "0012:BEEF\015\012");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
